// File: rtl/ds18b20_pkg.sv
// Shared constants and enums for the DS18B20 sequencer: ROM/function commands,
// bit counts, error codes and FSM state encodings.
package ds18b20_pkg;

  localparam logic [7:0] CMD_SKIP_ROM     = 8'hCC;
  localparam logic [7:0] CMD_CONVERT_T    = 8'h44;
  localparam logic [7:0] CMD_READ_SCRATCH = 8'hBE;

  localparam int SCRATCH_BITS  = 72;
  localparam int CMD_PAIR_BITS = 16;

  localparam logic [15:0] TEMP_POR = 16'h0550;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'd0,
    ERR_NO_PRESENCE = 2'd1,
    ERR_CRC         = 2'd2,
    ERR_TIMEOUT     = 2'd3
  } err_code_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST1,
    ST_CNV,
    ST_WAITC,
    ST_RST2,
    ST_RDC,
    ST_RD,
    ST_CHK,
    ST_ERR
  } state_e;

  // Phase of the bus-operation handshake used inside every bus step.
  typedef enum logic [1:0] {
    OP_ISSUE,
    OP_WLOW,
    OP_WHIGH
  } op_e;

endpackage

// File: rtl/ds_crc8.sv
// Dallas/Maxim CRC-8 (x^8+x^5+x^4+1, reflected, init 0) over 64 LSB-first bits.
// Only defined when DS_CRC_CHECK_EN is set, so the default build carries no CRC logic.
`ifdef DS_CRC_CHECK_EN
module ds_crc8 (
  input  logic [63:0] data,
  output logic [7:0]  crc
);

  logic [7:0] c;

  always_comb begin
    c = 8'h00;
    for (int i = 0; i < 64; i++) begin
      if (c[0] ^ data[i]) c = {1'b0, c[7:1]} ^ 8'h8C;
      else                c = {1'b0, c[7:1]};
    end
    crc = c;
  end

endmodule
`endif

// File: rtl/ds18b20_seq_ctrl.sv
// DS18B20 measurement sequencer driving the 1-Wire bit block through a full cycle.
// Define DS_CRC_CHECK_EN to validate the scratchpad CRC-8 before accepting TEMP.
module ds18b20_seq_ctrl
  import ds18b20_pkg::*;
#(
  parameter int CONV_WAIT_CYCLES  = 3000000,
  parameter int OP_TIMEOUT_CYCLES = 200000,
  parameter int CNT_W             = 22
) (
  input  logic        DS_CTRL_CLK,
  input  logic        DS_CTRL_RST,
  input  logic        START,
  output logic        BUSY,
  output logic [15:0] TEMP,
  output logic        TEMP_VALID,
  output logic        ERR,
  output logic [1:0]  ERR_CODE,
  output logic        OW_RW,
  output logic [79:0] OW_DATA_TO_SEND,
  output logic [7:0]  OW_COUNTER,
  output logic        OW_ENABLE,
  output logic        OW_INIT,
  input  logic [79:0] OW_DATA_RECEIVED,
  input  logic        OW_READY,
  input  logic        OW_LINE_OK
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(CONV_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(OP_TIMEOUT_CYCLES - 1);

  state_e           state;
  op_e              op_ph;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  logic             iss_init;
  logic             iss_rw;
  logic [7:0]       iss_cnt;
  logic [79:0]      iss_data;
  logic             data_bad;

  // Shared wait/watchdog counter saturates instead of wrapping.
  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

`ifdef DS_CRC_CHECK_EN
  logic [7:0] crc_calc;
  logic       unused_rx;

  ds_crc8 u_crc (
    .data (OW_DATA_RECEIVED[63:0]),
    .crc  (crc_calc)
  );

  // An all-zero scratchpad passes the CRC trivially, so it is rejected explicitly.
  assign data_bad  = (crc_calc != OW_DATA_RECEIVED[71:64]) ||
                     (OW_DATA_RECEIVED[71:0] == 72'h0);
  assign unused_rx = ^OW_DATA_RECEIVED[79:72];
`else
  logic unused_rx;

  assign data_bad  = 1'b0;
  assign unused_rx = ^OW_DATA_RECEIVED[79:16];
`endif

  // Operation descriptor for the bus step the FSM is currently in.
  always_comb begin
    iss_init = 1'b0;
    iss_rw   = 1'b0;
    iss_cnt  = 8'h00;
    iss_data = 80'h0;
    case (state)
      ST_RST1, ST_RST2: iss_init = 1'b1;
      ST_CNV: begin
        iss_cnt        = 8'(CMD_PAIR_BITS);
        iss_data[15:0] = {CMD_CONVERT_T, CMD_SKIP_ROM};
      end
      ST_RDC: begin
        iss_cnt        = 8'(CMD_PAIR_BITS);
        iss_data[15:0] = {CMD_READ_SCRATCH, CMD_SKIP_ROM};
      end
      ST_RD: begin
        iss_rw  = 1'b1;
        iss_cnt = 8'(SCRATCH_BITS);
      end
      default: ;
    endcase
  end

  always_ff @(posedge DS_CTRL_CLK) begin
    if (DS_CTRL_RST) begin
      state           <= ST_IDLE;
      op_ph           <= OP_ISSUE;
      cnt             <= '0;
      BUSY            <= 1'b0;
      TEMP            <= TEMP_POR;
      TEMP_VALID      <= 1'b0;
      ERR             <= 1'b0;
      ERR_CODE        <= ERR_NONE;
      OW_RW           <= 1'b0;
      OW_DATA_TO_SEND <= 80'h0;
      OW_COUNTER      <= 8'h00;
      OW_ENABLE       <= 1'b0;
      OW_INIT         <= 1'b0;
    end else begin
      TEMP_VALID <= 1'b0;
      ERR        <= 1'b0;
      case (state)
        // The bit block may still be finishing an op from before a reset.
        ST_IDLE: begin
          if (START && OW_READY) begin
            state    <= ST_RST1;
            op_ph    <= OP_ISSUE;
            BUSY     <= 1'b1;
            ERR_CODE <= ERR_NONE;
          end
        end

        ST_WAITC: begin
          if (cnt >= WAIT_LAST) begin
            state <= ST_RST2;
            op_ph <= OP_ISSUE;
          end else begin
            cnt <= cnt_inc;
          end
        end

        ST_CHK: begin
          if (data_bad) begin
            state    <= ST_ERR;
            ERR      <= 1'b1;
            ERR_CODE <= ERR_CRC;
          end else begin
            state      <= ST_IDLE;
            BUSY       <= 1'b0;
            TEMP       <= OW_DATA_RECEIVED[15:0];
            TEMP_VALID <= 1'b1;
            ERR_CODE   <= ERR_NONE;
          end
        end

        // ERR was raised on entry; this cycle is the pulse.
        ST_ERR: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end

        ST_RST1, ST_CNV, ST_RST2, ST_RDC, ST_RD: begin
          case (op_ph)
            OP_ISSUE: begin
              OW_INIT         <= iss_init;
              OW_RW           <= iss_rw;
              OW_COUNTER      <= iss_cnt;
              OW_DATA_TO_SEND <= iss_data;
              OW_ENABLE       <= 1'b1;
              cnt             <= '0;
              op_ph           <= OP_WLOW;
            end

            OP_WLOW: begin
              if (!OW_READY) begin
                OW_ENABLE <= 1'b0;
                op_ph     <= OP_WHIGH;
                cnt       <= cnt_inc;
              end else if (cnt >= TO_LAST) begin
                OW_ENABLE <= 1'b0;
                state     <= ST_ERR;
                ERR       <= 1'b1;
                ERR_CODE  <= ERR_TIMEOUT;
              end else begin
                cnt <= cnt_inc;
              end
            end

            // READY is checked before the watchdog so completion wins a tie.
            OP_WHIGH: begin
              if (OW_READY) begin
                op_ph <= OP_ISSUE;
                case (state)
                  ST_RST1, ST_RST2: begin
                    if (OW_LINE_OK) begin
                      state <= (state == ST_RST1) ? ST_CNV : ST_RDC;
                    end else begin
                      state    <= ST_ERR;
                      ERR      <= 1'b1;
                      ERR_CODE <= ERR_NO_PRESENCE;
                    end
                  end
                  ST_CNV: begin
                    state <= ST_WAITC;
                    cnt   <= '0;
                  end
                  ST_RDC:  state <= ST_RD;
                  default: state <= ST_CHK;
                endcase
              end else if (cnt >= TO_LAST) begin
                state    <= ST_ERR;
                ERR      <= 1'b1;
                ERR_CODE <= ERR_TIMEOUT;
              end else begin
                cnt <= cnt_inc;
              end
            end

            default: op_ph <= OP_ISSUE;
          endcase
        end

        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ds18b20_seq_ctrl.sv
// Scoreboard bench for ds18b20_seq_ctrl with a behavioural 1-Wire bit-block model.
// Expected bus ops and results are queued at START; monitors pop and compare.
`timescale 1ns/1ps
module tb_ds18b20_seq_ctrl;

  localparam int CONV_W = 40;
  localparam int TO_W   = 100;
  localparam int CW     = 22;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic [15:0] temp;
  logic        temp_valid;
  logic        err;
  logic [1:0]  err_code;
  logic        ow_rw;
  logic [79:0] ow_data;
  logic [7:0]  ow_cnt;
  logic        ow_en;
  logic        ow_init;
  logic [79:0] ow_rx = 80'h0;
  logic        ow_ready = 1'b1;
  logic        ow_line_ok = 1'b0;

  always #125 clk = ~clk;

  ds18b20_seq_ctrl #(
    .CONV_WAIT_CYCLES  (CONV_W),
    .OP_TIMEOUT_CYCLES (TO_W),
    .CNT_W             (CW)
  ) dut (
    .DS_CTRL_CLK      (clk),
    .DS_CTRL_RST      (rst),
    .START            (start),
    .BUSY             (busy),
    .TEMP             (temp),
    .TEMP_VALID       (temp_valid),
    .ERR              (err),
    .ERR_CODE         (err_code),
    .OW_RW            (ow_rw),
    .OW_DATA_TO_SEND  (ow_data),
    .OW_COUNTER       (ow_cnt),
    .OW_ENABLE        (ow_en),
    .OW_INIT          (ow_init),
    .OW_DATA_RECEIVED (ow_rx),
    .OW_READY         (ow_ready),
    .OW_LINE_OK       (ow_line_ok)
  );

  typedef struct packed {
    logic        init;
    logic        rw;
    logic [7:0]  cnt;
    logic [79:0] data;
  } op_t;

  typedef struct packed {
    logic        is_err;
    logic [1:0]  code;
    logic [15:0] temp;
  } res_t;

  op_t  exp_ops[$];
  res_t exp_res[$];
  int   n_chk = 0;
  int   n_err = 0;
  longint cyc = 0;
  longint en_cyc = 0;
  longint err_cyc = 0;
  int   ops_done = 0;
  logic presence = 1'b1;
  logic hang_cnv = 1'b0;
  logic hang = 1'b0;
  logic [71:0] scratch = 72'h0;
  logic [71:0] scr_good, scr_bad, scr_neg;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [63:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < 64; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 8'h8C;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // Bit-block model: accepts an op on ENABLE while idle, busy a few cycles, then READY.
  initial begin
    op_t cur;
    op_t e;
    int  busy_left;
    logic en_q;
    cur = '0;
    busy_left = 0;
    en_q = 1'b0;
    forever begin
      @(negedge clk);
      if (ow_en && !en_q) en_cyc = cyc;
      en_q = ow_en;
      if (!ow_ready) begin
        if (busy_left > 0) busy_left--;
        else if (!hang) begin
          ow_ready = 1'b1;
          if (cur.init) ow_line_ok = presence;
          if (cur.rw)   ow_rx = {8'h00, scratch};
          ops_done++;
        end
      end else if (ow_en) begin
        cur.init = ow_init;
        cur.rw   = ow_rw;
        cur.cnt  = ow_cnt;
        cur.data = ow_data;
        if (exp_ops.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_op: got init=%0b rw=%0b cnt=%0d data=%0h expected none",
                   cur.init, cur.rw, cur.cnt, cur.data);
        end else begin
          e = exp_ops.pop_front();
          check("op_init", 80'(cur.init), 80'(e.init));
          check("op_rw",   80'(cur.rw),   80'(e.rw));
          check("op_cnt",  80'(cur.cnt),  80'(e.cnt));
          check("op_data", cur.data,      e.data);
        end
        ow_ready  = 1'b0;
        busy_left = 3;
        if (hang_cnv && !cur.init && cur.data[15:0] == 16'h44CC) hang = 1'b1;
      end
    end
  end

  // Result monitor: every TEMP_VALID/ERR pulse is matched against the queue.
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (temp_valid || err) begin
        if (err) err_cyc = cyc;
        if (exp_res.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_result: got valid=%0b err=%0b code=%0d temp=%0h expected none",
                   temp_valid, err, err_code, temp);
        end else begin
          r = exp_res.pop_front();
          check("res_err",   80'(err),        80'(r.is_err));
          check("res_valid", 80'(temp_valid), 80'(!r.is_err));
          check("res_code",  80'(err_code),   80'(r.code));
          check("res_temp",  80'(temp),       80'(r.temp));
        end
        @(negedge clk);
        check("pulse_width", 80'({temp_valid, err}), 80'(0));
      end
    end
  end

  task automatic push_op(input logic init, input logic rw, input logic [7:0] cnt,
                         input logic [15:0] data);
    op_t o;
    o.init = init;
    o.rw   = rw;
    o.cnt  = cnt;
    o.data = {64'h0, data};
    exp_ops.push_back(o);
  endtask

  task automatic push_res(input logic is_err, input logic [1:0] code, input logic [15:0] t);
    res_t r;
    r.is_err = is_err;
    r.code   = code;
    r.temp   = t;
    exp_res.push_back(r);
  endtask

  task automatic push_full_ops();
    push_op(1'b1, 1'b0, 8'd0,  16'h0000);
    push_op(1'b0, 1'b0, 8'd16, 16'h44CC);
    push_op(1'b1, 1'b0, 8'd0,  16'h0000);
    push_op(1'b0, 1'b0, 8'd16, 16'hBECC);
    push_op(1'b0, 1'b1, 8'd72, 16'h0000);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_res.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, 80'(n < 2000), 80'(1));
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ow_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 80'(ow_ready), 80'(1));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},  80'(busy),       80'(0));
    check({tag, "_temp"},  80'(temp),       80'(16'h0550));
    check({tag, "_tv"},    80'(temp_valid), 80'(0));
    check({tag, "_err"},   80'(err),        80'(0));
    check({tag, "_code"},  80'(err_code),   80'(0));
    check({tag, "_en"},    80'(ow_en),      80'(0));
    check({tag, "_init"},  80'(ow_init),    80'(0));
    check({tag, "_rw"},    80'(ow_rw),      80'(0));
    check({tag, "_cnt"},   80'(ow_cnt),     80'(0));
    check({tag, "_data"},  ow_data,         80'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    scr_good = 72'h1C_10_0C_FF_7F_46_4B_05_50;
    scr_bad  = 72'h1D_10_0C_FF_7F_46_4B_05_50;
    scr_neg  = {8'h00, 64'h10_0C_FF_7F_46_4B_FF_5E};
    scr_neg[71:64] = crc8(scr_neg[63:0]);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_vals("reset");

    // Good cycle
    scratch = scr_good;
    push_full_ops();
    push_res(1'b0, 2'd0, 16'h0550);
    pulse_start();
    check("busy_after_start", 80'(busy), 80'(1));
    wait_done("good_done");
    check("good_code", 80'(err_code), 80'(0));

    // No presence on first reset: only the reset op, then ERR code 1
    presence = 1'b0;
    push_op(1'b1, 1'b0, 8'd0, 16'h0000);
    push_res(1'b1, 2'd1, 16'h0550);
    pulse_start();
    wait_done("nopres_done");
    repeat (5) @(negedge clk);
    check("nopres_code_held", 80'(err_code), 80'(1));
    check("nopres_temp", 80'(temp), 80'(16'h0550));
    presence = 1'b1;

    // Corrupted CRC byte
    scratch = scr_bad;
    push_full_ops();
`ifdef DS_CRC_CHECK_EN
    push_res(1'b1, 2'd2, 16'h0550);
`else
    push_res(1'b0, 2'd0, 16'h0550);
`endif
    pulse_start();
    wait_done("crc_done");

    // Bit block hangs after the Convert T write: watchdog fires
    hang_cnv = 1'b1;
    push_op(1'b1, 1'b0, 8'd0,  16'h0000);
    push_op(1'b0, 1'b0, 8'd16, 16'h44CC);
    push_res(1'b1, 2'd3, 16'h0550);
    pulse_start();
    wait_done("timeout_done");
    check("timeout_latency", 80'(err_cyc - en_cyc), 80'(TO_W));
    check("timeout_busy", 80'(busy), 80'(0));
    check("timeout_code", 80'(err_code), 80'(3));
    hang_cnv = 1'b0;
    hang = 1'b0;
    wait_ready("timeout_release");

    // Negative temperature
    scratch = scr_neg;
    push_full_ops();
    push_res(1'b0, 2'd0, 16'hFF5E);
    pulse_start();
    wait_done("neg_done");
    check("neg_temp_hold", 80'(temp), 80'(16'hFF5E));

    // Reset during the conversion wait while the bit block looks busy
    push_op(1'b1, 1'b0, 8'd0,  16'h0000);
    push_op(1'b0, 1'b0, 8'd16, 16'h44CC);
    n = ops_done + 2;
    pulse_start();
    begin
      int k;
      k = 0;
      while (ops_done < n && k < 500) begin
        @(negedge clk);
        k++;
      end
      check("reach_waitc", 80'(ops_done >= n), 80'(1));
    end
    repeat (5) @(negedge clk);
    hang = 1'b1;
    ow_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("midrst");
    pulse_start();
    repeat (5) @(negedge clk);
    check("start_ignored_busy", 80'(busy), 80'(0));
    hang = 1'b0;
    wait_ready("midrst_release");
    repeat (2) @(negedge clk);
    push_full_ops();
    push_res(1'b0, 2'd0, 16'hFF5E);
    pulse_start();
    check("busy_after_restart", 80'(busy), 80'(1));
    wait_done("restart_done");

    check("ops_drained", 80'(exp_ops.size()), 80'(0));
    check("res_drained", 80'(exp_res.size()), 80'(0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
